// File: rtl/hangman_pkg.sv
// rtl/hangman_pkg.sv - shared types and key codes for the hangman keypad/UART path
package hangman_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STROBE     = 2'd1,
    WAIT_BUSY  = 2'd2,
    WAIT_READY = 2'd3
  } tx_sched_state_t;

  // Control bytes sent to the host; keypad_fsm uses the same values for its keys.
  localparam logic [7:0] CODE_WORD = 8'h0D;
  localparam logic [7:0] CODE_END  = 8'h04;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - 8-bit synchronous FIFO with push/pop/flush and exact occupancy
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [7:0]                   push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [7:0]                   head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  // Pointers and occupancy; flush restarts at slot 0, keeping a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge clk) begin
    if (flush && push) begin
      mem[0] <= push_data;
    end else if (!flush && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - arbitrates keypad message sources onto the shared UART transmitter
module uart_tx_scheduler #(
  parameter int         DEPTH     = 4,
  parameter int         TIMEOUT   = 16,
  parameter logic [7:0] CODE_WORD = hangman_pkg::CODE_WORD,
  parameter logic [7:0] CODE_END  = hangman_pkg::CODE_END
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         letter_valid,
  input  logic [7:0]                   letter_data,
  input  logic                         word_submit,
  input  logic                         game_end,
  input  logic                         txready,
  output logic [7:0]                   txdata,
  output logic                         txclk,
  output logic                         busy,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  import hangman_pkg::*;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  tx_sched_state_t state;
  tx_sched_state_t state_nx;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_nx;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_flush;
  logic [7:0]      push_byte;
  logic [7:0]      head;
  logic            full;
  logic            empty;
  logic            drop;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_byte),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Pick one writer per cycle (game_end > word_submit > letter) and flag anything lost.
  always_comb begin
    fifo_flush = game_end;
    fifo_push  = 1'b0;
    push_byte  = 8'h00;
    drop       = 1'b0;
    if (game_end) begin
      fifo_push = 1'b1;
      push_byte = CODE_END;
      drop      = word_submit | letter_valid;
    end else if (word_submit) begin
      fifo_push = 1'b1;
      push_byte = CODE_WORD;
      drop      = letter_valid | (full & ~fifo_pop);
    end else if (letter_valid) begin
      fifo_push = 1'b1;
      push_byte = letter_data;
      drop      = full & ~fifo_pop;
    end
  end

  // Launch sequencing: pop, strobe, wait for the UART to go busy (or give up), wait for idle.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    fifo_pop = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && txready) begin
          fifo_pop = 1'b1;
          state_nx = STROBE;
        end
      end
      STROBE: begin
        state_nx = WAIT_BUSY;
        timer_nx = '0;
      end
      WAIT_BUSY: begin
        if (!txready || timer == TW'(TIMEOUT - 1)) begin
          state_nx = WAIT_READY;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      WAIT_READY: begin
        if (txready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, timer and registered UART-facing outputs; overflow is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      txdata   <= 8'h00;
      txclk    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      txclk <= (state_nx == STROBE);
      if (fifo_pop) txdata   <= head;
      if (drop)     overflow <= 1'b1;
    end
  end

  assign busy = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler against a queue/timestamp model
module tb_uart_tx_scheduler;

  localparam int         DEPTH   = 4;
  localparam int         TIMEOUT = 16;
  localparam logic [7:0] B_WORD  = 8'h0D;
  localparam logic [7:0] B_END   = 8'h04;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       letter_valid = 1'b0;
  logic [7:0] letter_data = 8'h00;
  logic       word_submit = 1'b0;
  logic       game_end = 1'b0;
  logic       txready = 1'b0;
  logic [7:0] txdata;
  logic       txclk;
  logic       busy;
  logic       overflow;
  logic [2:0] count;

  uart_tx_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .letter_valid (letter_valid),
    .letter_data  (letter_data),
    .word_submit  (word_submit),
    .game_end     (game_end),
    .txready      (txready),
    .txdata       (txdata),
    .txclk        (txclk),
    .busy         (busy),
    .overflow     (overflow),
    .count        (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: a byte queue plus timestamps of the current launch.
  // pop_e  = edge at which the byte was taken (strobe visible right after it)
  // drop_e = edge at which the UART was seen busy, or the wait gave up
  // rise_e = first later edge with the UART ready again; idle from then on
  logic [7:0] mq[$];
  bit         m_ovf;
  logic [7:0] m_tx;
  int         m_edge, pop_e, drop_e, rise_e;

  logic [7:0] sent[$];
  int         strobe_at[$];
  int         tick_no;

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_tx   = 8'h00;
    m_edge = 0;
    pop_e  = -1;
    drop_e = -1;
    rise_e = -1;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic model_edge(input logic lv, input logic [7:0] ld, input logic ws,
                            input logic ge, input logic tr);
    bit idle;
    m_edge++;
    idle = (pop_e < 0) || (rise_e >= 0 && m_edge > rise_e);
    if (!idle) begin
      if (drop_e < 0) begin
        if (m_edge >= pop_e + 2 && (!tr || m_edge == pop_e + 1 + TIMEOUT)) drop_e = m_edge;
      end else if (rise_e < 0 && tr) begin
        rise_e = m_edge;
      end
    end
    if (idle && mq.size() > 0 && tr) begin
      m_tx   = mq.pop_front();
      pop_e  = m_edge;
      drop_e = -1;
      rise_e = -1;
    end
    if (ge) begin
      mq.delete();
      mq.push_back(B_END);
      if (ws || lv) m_ovf = 1'b1;
    end else if (ws) begin
      model_push(B_WORD);
      if (lv) m_ovf = 1'b1;
    end else if (lv) begin
      model_push(ld);
    end
  endtask

  task automatic tick(input logic lv, input logic [7:0] ld, input logic ws, input logic ge);
    bit exp_clk, exp_busy;
    letter_valid = lv;
    letter_data  = ld;
    word_submit  = ws;
    game_end     = ge;
    @(posedge clk);
    model_edge(lv, ld, ws, ge, txready);
    @(negedge clk);
    letter_valid = 1'b0;
    word_submit  = 1'b0;
    game_end     = 1'b0;
    exp_clk  = (pop_e == m_edge);
    exp_busy = (mq.size() != 0) || !(pop_e < 0 || (rise_e >= 0 && m_edge >= rise_e));
    check_eq("txclk", txclk, exp_clk);
    check_eq("txdata", txdata, m_tx);
    check_eq("count", count, mq.size());
    check_eq("busy", busy, exp_busy);
    check_eq("overflow", overflow, m_ovf);
    tick_no++;
    if (txclk) begin
      sent.push_back(txdata);
      strobe_at.push_back(tick_no);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_txclk"}, txclk, 0);
    check_eq({tag, "_txdata"}, txdata, 8'h00);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_overflow"}, overflow, 0);
    check_eq({tag, "_count"}, count, 0);
  endtask

  task automatic do_reset(input string tag);
    letter_valid = 1'b0;
    word_submit  = 1'b0;
    game_end     = 1'b0;
    txready      = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sent.delete();
    strobe_at.delete();
  endtask

  // UART stand-in: goes busy for two cycles after each strobe, otherwise ready.
  task automatic uart_ticks(input int n);
    int hold = 0;
    for (int i = 0; i < n; i++) begin
      txready = (hold == 0);
      if (hold > 0) hold--;
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      if (txclk) hold = 2;
    end
  endtask

  initial begin
    tick_no = 0;
    model_reset();
    #2;

    // 1: single letter with UART held ready
    do_reset("rst1");
    txready = 1'b1;
    tick(1'b1, 8'h41, 1'b0, 1'b0);
    check_eq("t1_clk_n1", txclk, 0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("t1_clk_n2", txclk, 1);
    check_eq("t1_data", txdata, 8'h41);
    for (int i = 0; i < 25; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("t1_sent_n", sent.size(), 1);
    check_eq("t1_busy_end", busy, 0);
    check_eq("t1_data_held", txdata, 8'h41);

    // 2: overflow while the UART is stalled
    do_reset("rst2");
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
    check_eq("t2_count", count, 4);
    check_eq("t2_overflow", overflow, 1);
    uart_ticks(60);
    check_eq("t2_sent_n", sent.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < sent.size()) check_eq("t2_sent", sent[i], 8'h41 + 8'(i));

    // 3: letter and word_submit in the same cycle
    do_reset("rst3");
    tick(1'b1, 8'h5A, 1'b1, 1'b0);
    check_eq("t3_count", count, 1);
    check_eq("t3_overflow", overflow, 1);
    uart_ticks(20);
    check_eq("t3_sent_n", sent.size(), 1);
    if (sent.size() > 0) check_eq("t3_sent", sent[0], B_WORD);

    // 4: game_end flushes pending letters
    do_reset("rst4");
    tick(1'b1, 8'h50, 1'b0, 1'b0);
    tick(1'b1, 8'h51, 1'b0, 1'b0);
    tick(1'b1, 8'h52, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("t4_count", count, 1);
    uart_ticks(40);
    check_eq("t4_sent_n", sent.size(), 1);
    if (sent.size() > 0) check_eq("t4_sent", sent[0], B_END);

    // 5: txready never drops after launch
    do_reset("rst5");
    tick(1'b1, 8'h58, 1'b0, 1'b0);
    tick(1'b1, 8'h59, 1'b0, 1'b0);
    txready = 1'b1;
    for (int i = 0; i < 45; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("t5_sent_n", sent.size(), 2);
    if (sent.size() == 2) begin
      check_eq("t5_gap", strobe_at[1] - strobe_at[0], TIMEOUT + 3);
      check_eq("t5_second", sent[1], 8'h59);
    end

    // 6: reset while waiting for the UART with bytes still queued
    do_reset("rst6");
    tick(1'b1, 8'h4A, 1'b0, 1'b0);
    tick(1'b1, 8'h4B, 1'b0, 1'b0);
    tick(1'b1, 8'h4C, 1'b0, 1'b0);
    txready = 1'b1;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    txready = 1'b0;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("t6_pre_count", count, 2);
    do_reset("t6_async");
    txready = 1'b1;
    for (int i = 0; i < 20; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("t6_quiet", sent.size(), 0);
    tick(1'b1, 8'h4D, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("t6_new_n", sent.size(), 1);
    if (sent.size() > 0) check_eq("t6_new", sent[0], 8'h4D);

    // Random traffic against the model
    do_reset("rst_rand");
    for (int i = 0; i < 1500; i++) begin
      if ((i % 300) < 80) txready = 1'b1;
      else txready = ($urandom_range(0, 3) != 0);
      tick($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 39) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
